// File: rtl/cpu6_pipeline_ctrl_if.sv
// rtl/cpu6_pipeline_ctrl_if.sv - hazard inputs and stall/flush controls of the cpu6 pipeline controller
// master: the pipeline datapath; slave: cpu6_pipeline_ctrl.
interface cpu6_pipeline_ctrl_if;
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic [4:0] rdE;
  logic       memtoregE;
  logic       regwriteE;
  logic       redirectE;
  logic       memreqM;
  logic       memackM;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       flushD;
  logic       flushE;
  logic       bubbleW;
  logic       pcsel_redirect;
  logic       mem_timeout;

  modport master (
    output rs1D, rs2D, rdE, memtoregE, regwriteE, redirectE, memreqM, memackM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, bubbleW,
           pcsel_redirect, mem_timeout
  );

  modport slave (
    input  rs1D, rs2D, rdE, memtoregE, regwriteE, redirectE, memreqM, memackM,
    output stallF, stallD, stallE, stallM, flushD, flushE, bubbleW,
           pcsel_redirect, mem_timeout
  );
endinterface

// File: rtl/cpu6_pipeline_ctrl.sv
// rtl/cpu6_pipeline_ctrl.sv - stall/flush sequencer for the cpu6 5-stage pipeline
// Optional performance counters are enabled with `define CPU6_PIPECTRL_PERF_EN.
module cpu6_pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CPU6_PIPECTRL_PERF_EN
  input  logic        perf_clr,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [15:0] perf_timeout_cnt,
`endif
  cpu6_pipeline_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MWAIT  = 2'd1,
    ST_RDHOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic   load_use;
  logic   mem_wait;
  state_t state_eff;
  logic   pend_eff;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, bubble_w, pcsel, tmo;

  assign load_use = pif.memtoregE & pif.regwriteE & (pif.rdE != 5'd0) &
                    ((pif.rdE == pif.rs1D) | (pif.rdE == pif.rs2D));
  assign mem_wait = pif.memreqM & ~pif.memackM;

  // Reset takes effect in its own cycle: the outputs already see a RUN machine.
  assign state_eff = reset ? ST_RUN : state_q;
  assign pend_eff  = reset ? 1'b0 : pend_q;

  always_comb begin
    state_d  = state_eff;
    cnt_d    = cnt_q;
    pend_d   = pend_eff;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    pcsel    = 1'b0;
    tmo      = 1'b0;

    unique case (state_eff)
      ST_RUN, ST_RDHOLD: begin
        if (mem_wait) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          bubble_w = 1'b1;
          state_d  = ST_MWAIT;
          cnt_d    = CNT_W'(1);
          // E is frozen by the wait, so a live redirect must not be lost.
          pend_d   = pend_eff | pif.redirectE;
        end else if (pif.redirectE || state_eff == ST_RDHOLD) begin
          pcsel   = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_RUN;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      ST_MWAIT: begin
        if (pif.memackM) begin
          pend_d  = pend_eff | pif.redirectE;
          state_d = pend_d ? ST_RDHOLD : ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= TMO_LAST) begin
          // Abort: treat as complete but keep the bubble so nothing is written back.
          tmo      = 1'b1;
          bubble_w = 1'b1;
          pend_d   = pend_eff | pif.redirectE;
          state_d  = pend_d ? ST_RDHOLD : ST_RUN;
          cnt_d    = '0;
        end else begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          bubble_w = 1'b1;
          pend_d   = pend_eff | pif.redirectE;
          cnt_d    = (cnt_q >= TMO_MAX) ? TMO_MAX : cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign pif.stallF         = stall_f;
  assign pif.stallD         = stall_d;
  assign pif.stallE         = stall_e;
  assign pif.stallM         = stall_m;
  assign pif.flushD         = flush_d;
  assign pif.flushE         = flush_e;
  assign pif.bubbleW        = bubble_w;
  assign pif.pcsel_redirect = pcsel;
  assign pif.mem_timeout    = tmo;

`ifdef CPU6_PIPECTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [15:0] perf_tmo_q, perf_tmo_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_f};
    perf_flush_d = perf_flush_q + {31'd0, flush_e};
    perf_tmo_d   = perf_tmo_q + {15'd0, tmo};
    if (perf_clr) begin
      perf_stall_d = '0;
      perf_flush_d = '0;
      perf_tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_tmo_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_tmo_q   <= perf_tmo_d;
    end
  end

  assign perf_stall_cnt   = perf_stall_q;
  assign perf_flush_cnt   = perf_flush_q;
  assign perf_timeout_cnt = perf_tmo_q;
`else
  // Core-only build: no event counters.
`endif

endmodule

// File: tb/tb_cpu6_pipeline_ctrl.sv
// tb/tb_cpu6_pipeline_ctrl.sv - directed self-checking bench for cpu6_pipeline_ctrl
// Output vector order: {stallF,stallD,stallE,stallM,flushD,flushE,bubbleW,pcsel_redirect,mem_timeout}
module tb_cpu6_pipeline_ctrl;
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] RD   = 9'b000011010;
  localparam logic [8:0] WT   = 9'b111100100;
  localparam logic [8:0] TO   = 9'b000000101;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [8:0] obs;

  cpu6_pipeline_ctrl_if pif ();

`ifdef CPU6_PIPECTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [15:0] perf_timeout_cnt;
`endif

  cpu6_pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
`ifdef CPU6_PIPECTRL_PERF_EN
    .perf_clr         (perf_clr),
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_flush_cnt   (perf_flush_cnt),
    .perf_timeout_cnt (perf_timeout_cnt),
`endif
    .pif              (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] outs();
    return {pif.stallF, pif.stallD, pif.stallE, pif.stallM, pif.flushD,
            pif.flushE, pif.bubbleW, pif.pcsel_redirect, pif.mem_timeout};
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mtr, input logic rw, input logic redir,
                        input logic req, input logic ack);
    pif.rs1D      = rs1;
    pif.rs2D      = rs2;
    pif.rdE       = rd;
    pif.memtoregE = mtr;
    pif.regwriteE = rw;
    pif.redirectE = redir;
    pif.memreqM   = req;
    pif.memackM   = ack;
  endtask

  task automatic quiet();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] exp [2] = '{NONE, NONE};
    quiet();
    reset = 1'b1;
    step();
    for (int c = 0; c < 2; c++) begin
      reset = (c == 0);
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL reset_c%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    logic [4:0] rs1 [6] = '{5'd5, 5'd1, 5'd0, 5'd5, 5'd9, 5'd5};
    logic [4:0] rs2 [6] = '{5'd2, 5'd7, 5'd0, 5'd2, 5'd8, 5'd2};
    logic [4:0] rd  [6] = '{5'd5, 5'd7, 5'd0, 5'd5, 5'd3, 5'd4};
    logic       mtr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       rw  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [8:0] exp [6] = '{LU, LU, NONE, NONE, NONE, NONE};
    for (int c = 0; c < 6; c++) begin
      set_in(rs1[c], rs2[c], rd[c], mtr[c], rw[c], 1'b0, 1'b0, 1'b0);
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL load_use_v%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
      quiet();
      #1;
      obs = outs();
      tests++;
      if (obs !== NONE) begin
        fails++;
        $display("FAIL load_use_after_v%0d: got %b want %b", c, obs, NONE);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    logic [8:0] exp [3] = '{RD, RD, NONE};
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_in(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (c == 1) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else quiet();
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL redirect_c%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
    end
  endtask

  task automatic test_mem_wait();
    logic [8:0] exp [6] = '{WT, WT, WT, NONE, LU, NONE};
    for (int c = 0; c < 6; c++) begin
      if (c < 3) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (c == 3) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      else if (c == 4) set_in(5'd6, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      else set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL mem_wait_c%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    logic [8:0] exp [6] = '{WT, WT, WT, TO, NONE, NONE};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else quiet();
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL timeout_c%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
    end
  endtask

  task automatic test_held_redirect();
    logic [8:0] exp [6] = '{WT, WT, WT, NONE, RD, NONE};
    for (int c = 0; c < 6; c++) begin
      if (c == 0 || c == 2) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (c == 1) set_in(5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      else if (c == 3) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      else quiet();
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL held_redirect_c%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
    end
  endtask

  task automatic test_rdhold_memwait();
    logic [8:0] exp [7] = '{WT, WT, NONE, WT, NONE, RD, NONE};
    for (int c = 0; c < 7; c++) begin
      if (c == 0 || c == 3) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (c == 1) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      else if (c == 2 || c == 4) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      else quiet();
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL rdhold_memwait_c%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [8:0] exp [5] = '{WT, WT, NONE, NONE, NONE};
    for (int c = 0; c < 5; c++) begin
      reset = (c == 2);
      if (c == 0) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (c == 1) set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      else quiet();
      #1;
      obs = outs();
      tests++;
      if (obs !== exp[c]) begin
        fails++;
        $display("FAIL reset_mid_wait_c%0d: got %b want %b", c, obs, exp[c]);
      end
      step();
    end
    reset = 1'b0;
  endtask

`ifdef CPU6_PIPECTRL_PERF_EN
  task automatic test_perf();
    quiet();
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    set_in(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    quiet();
    #1;
    tests++;
    if (perf_stall_cnt !== 32'd5) begin
      fails++;
      $display("FAIL perf_stall: got %0d want 5", perf_stall_cnt);
    end
    tests++;
    if (perf_flush_cnt !== 32'd5) begin
      fails++;
      $display("FAIL perf_flush: got %0d want 5", perf_flush_cnt);
    end
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    #1;
    tests++;
    if (perf_stall_cnt !== 32'd0) begin
      fails++;
      $display("FAIL perf_clr: got %0d want 0", perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
`ifdef CPU6_PIPECTRL_PERF_EN
    perf_clr = 1'b0;
`endif
    quiet();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_held_redirect();
    test_rdhold_memwait();
    test_reset_mid_wait();
`ifdef CPU6_PIPECTRL_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
